// File: rtl/tmr_fault_monitor.sv
// Health monitor behind a 2-of-3 voter: samples the three lanes plus the voter's
// outputs, counts per-lane miscompares, tracks runs of faults on one lane and
// walks HEALTHY -> TRANSIENT -> DEGRADED -> FAILED, with a sticky flag for
// samples where the voter itself contradicts its lanes.
module tmr_fault_monitor #(
    parameter int PERSIST_N = 4,
    parameter int CNT_W     = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             lane_a,
    input  logic             lane_b,
    input  logic             lane_c,
    input  logic             voted,
    input  logic             voter_error,
    input  logic             clear,
    input  logic [1:0]       cnt_sel,
    output logic [1:0]       state,
    output logic [1:0]       iso_lane,
    output logic             alarm,
    output logic             incons,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [1:0] ST_HEALTHY   = 2'b00;
    localparam logic [1:0] ST_TRANSIENT = 2'b01;
    localparam logic [1:0] ST_DEGRADED  = 2'b10;
    localparam logic [1:0] ST_FAILED    = 2'b11;

    localparam logic [1:0] LANE_NONE = 2'b00;
    localparam logic [1:0] LANE_A    = 2'b01;
    localparam logic [1:0] LANE_B    = 2'b10;
    localparam logic [1:0] LANE_C    = 2'b11;

    // Run length only needs to reach PERSIST_N, which is at most 15.
    localparam int               RUN_W   = 4;
    localparam logic [RUN_W-1:0] PERSIST = RUN_W'(PERSIST_N);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             smp_a, smp_b, smp_c, smp_voted, smp_err;
    logic             lanes_agree, majority, inconsistent, persist_hit;
    logic [1:0]       fault_lane;
    logic [1:0]       run_lane, run_lane_nxt;
    logic [RUN_W-1:0] run_len, run_len_nxt;
    logic [1:0]       state_nxt, iso_nxt;
    logic [CNT_W-1:0] cnt [3];

    // Sample stage: every decision below looks only at these registered copies.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            smp_a     <= 1'b0;
            smp_b     <= 1'b0;
            smp_c     <= 1'b0;
            smp_voted <= 1'b0;
            smp_err   <= 1'b0;
        end else begin
            smp_a     <= lane_a;
            smp_b     <= lane_b;
            smp_c     <= lane_c;
            smp_voted <= voted;
            smp_err   <= voter_error;
        end
    end

    assign lanes_agree = (smp_a == smp_b) && (smp_b == smp_c);
    assign majority    = (smp_a & smp_b) | (smp_a & smp_c) | (smp_b & smp_c);
    // The voter is lying if its error flag or its majority disagrees with the lanes.
    assign inconsistent = (smp_err == lanes_agree) || (smp_voted != majority);

    // With single-bit lanes, disagreement always means exactly one odd lane out.
    always_comb begin
        fault_lane = LANE_NONE;
        if (!lanes_agree) begin
            if (smp_a == smp_b)      fault_lane = LANE_C;
            else if (smp_a == smp_c) fault_lane = LANE_B;
            else                     fault_lane = LANE_A;
        end
    end

    // Run tracker: a run only continues if the previous sample faulted the same lane.
    always_comb begin
        run_lane_nxt = run_lane;
        run_len_nxt  = run_len;
        if (fault_lane == LANE_NONE) begin
            run_len_nxt = '0;
        end else if (fault_lane == run_lane && run_len != '0) begin
            run_len_nxt = (run_len >= PERSIST) ? PERSIST : run_len + RUN_W'(1);
        end else begin
            run_lane_nxt = fault_lane;
            run_len_nxt  = RUN_W'(1);
        end
    end

    assign persist_hit = (fault_lane != LANE_NONE) && (run_len_nxt == PERSIST);

    // Health state transitions; an inconsistent sample overrides everything else.
    always_comb begin
        state_nxt = state;
        iso_nxt   = iso_lane;
        if (inconsistent) begin
            state_nxt = ST_FAILED;
        end else begin
            case (state)
                ST_HEALTHY: begin
                    if (fault_lane != LANE_NONE) state_nxt = ST_TRANSIENT;
                end
                ST_TRANSIENT: begin
                    if (fault_lane == LANE_NONE) begin
                        state_nxt = ST_HEALTHY;
                    end else if (persist_hit) begin
                        state_nxt = ST_DEGRADED;
                        iso_nxt   = run_lane_nxt;
                    end
                end
                ST_DEGRADED: begin
                    if (persist_hit && fault_lane != iso_lane) state_nxt = ST_FAILED;
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Monitor state registers; clear wipes everything except the sample stage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_HEALTHY;
            iso_lane <= LANE_NONE;
            alarm    <= 1'b0;
            incons   <= 1'b0;
            run_lane <= LANE_NONE;
            run_len  <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else if (clear) begin
            state    <= ST_HEALTHY;
            iso_lane <= LANE_NONE;
            alarm    <= 1'b0;
            incons   <= 1'b0;
            run_lane <= LANE_NONE;
            run_len  <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            state    <= state_nxt;
            iso_lane <= iso_nxt;
            alarm    <= (state_nxt == ST_FAILED);
            incons   <= incons | inconsistent;
            run_lane <= run_lane_nxt;
            run_len  <= run_len_nxt;
            for (int i = 0; i < 3; i++) begin
                if (fault_lane == 2'(i + 1) && cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + CNT_W'(1);
            end
        end
    end

    // Counter readout mux, no register in the path so cnt_sel takes effect at once.
    always_comb begin
        case (cnt_sel)
            2'b00:   err_count = cnt[0];
            2'b01:   err_count = cnt[1];
            2'b10:   err_count = cnt[2];
            default: err_count = '0;
        endcase
    end

endmodule

// File: doc/tmr_fault_monitor.md
TMR_FAULT_MONITOR -- requirements
Module: tmr_fault_monitor

Interface
REQ-001 SHALL have parameter PERSIST_N, default 4: consecutive same-lane miscompares that declare a lane persistently faulty (legal 2..15).
REQ-002 SHALL have parameter CNT_W, default 4: width of each per-lane error counter.
REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports lane_a, lane_b, lane_c, input, 1 each, registered redundant lanes from the upstream 2-of-3 voter.
REQ-006 SHALL have port voted, input, 1, the voter's majority output.
REQ-007 SHALL have port voter_error, input, 1, the voter's disagreement flag.
REQ-008 SHALL have port clear, input, 1, synchronous clear of all monitor state.
REQ-009 SHALL have port cnt_sel, input, 2, selects the counter shown on err_count (00 A, 01 B, 10 C, 11 zero).
REQ-010 SHALL have port state, output, 2, health state (00 HEALTHY, 01 TRANSIENT, 10 DEGRADED, 11 FAILED).
REQ-011 SHALL have port iso_lane, output, 2, isolated lane (00 none, 01 A, 10 B, 11 C).
REQ-012 SHALL have port alarm, output, 1, high exactly when state is FAILED.
REQ-013 SHALL have port incons, output, 1, sticky upstream-inconsistency flag.
REQ-014 SHALL have port err_count, output, CNT_W, selected per-lane error counter.

Function
REQ-015 SHALL register lane_a/b/c, voted and voter_error into a sample stage every edge; all decisions use only the sample stage.
REQ-016 SHALL decode the faulty lane from the sample stage as the single lane differing from the other two; none if all three agree.
REQ-017 SHALL treat a sample as inconsistent when voter_error disagrees with lane agreement, or voted differs from majority(lanes); an inconsistent sample sets incons and forces FAILED on the next edge.
REQ-018 SHALL increment the faulty lane's counter by 1 per faulty sample, saturating at 2^CNT_W-1 with no wrap.
REQ-019 SHALL track run_lane/run_len: same lane as previous faulty sample -> run_len+1 saturating at PERSIST_N; different lane -> run_lane=new, run_len=1; no faulty lane -> run_len=0.
REQ-020 SHALL transition HEALTHY -> TRANSIENT on any faulty sample.
REQ-021 SHALL transition TRANSIENT -> HEALTHY on a fault-free sample; TRANSIENT -> DEGRADED on the edge run_len reaches PERSIST_N, latching iso_lane = run_lane.
REQ-022 SHALL, in DEGRADED, ignore faults on iso_lane for state purposes (counters still count); DEGRADED -> FAILED when a different lane's run_len reaches PERSIST_N.
REQ-023 SHALL hold DEGRADED and FAILED until clear or reset; fault-free samples do not leave them.
REQ-024 SHALL give input-to-state latency of 2 edges: input at edge N sampled, state/counters/flags updated at edge N+1.
REQ-025 SHALL give clear priority over every same-cycle event: state HEALTHY, counters, run_len, iso_lane, incons zeroed on that edge; sample stage still loads.
REQ-026 SHALL drive err_count combinationally from cnt_sel and the counter registers (zero-cycle select latency).
REQ-027 SHALL register all other outputs directly from state registers (no combinational input-to-output path).

Reset
REQ-028 SHALL, on reset assertion, immediately clear sample stage, counters, run tracker, incons, iso_lane=00, state=HEALTHY, alarm=0, independent of clock.
REQ-029 SHALL, on reset mid-run (any state), discard partial runs; after release, the first sample is taken on the next rising edge.

Verification
REQ-030 SHALL cover: lanes 1,1,1 voted 1 error 0 for 10 cycles -> state 00, all counters 0, incons 0.
REQ-031 SHALL cover: one sample lane_b=0, others 1, voted 1, error 1 -> state 01 two edges later, 00 one edge after that; counter B=1.
REQ-032 SHALL cover: lane_c wrong 4 consecutive samples (PERSIST_N=4) -> state 10, iso_lane 11 on the edge after the fourth sample; later lane_c faults keep state 10.
REQ-033 SHALL cover: in DEGRADED(C), lane_a wrong 4 consecutive samples -> state 11, alarm 1; clear pulse -> state 00, iso_lane 00, err_count 0 for all cnt_sel.
REQ-034 SHALL cover: lanes 1,1,1 with voter_error 1 -> incons 1, state 11 next edge; lane_a wrong 20 samples with CNT_W=4 -> counter A saturates at 15.
REQ-035 SHALL cover: reset asserted between edges while state 10 -> outputs zero before next edge; clear and faulty sample in same cycle -> clear wins.
